// File: rtl/lzw_byte_feeder.sv
// lzw_byte_feeder: input stage of the LZW accelerator.
// Takes 64-bit words from the host stream over valid/ready and emits them one
// byte per cycle, LSB byte first, as byte_out/shift into the byte-window shift
// register. Handles partial words, zero-byte words, end-of-stream pulses and
// downstream stall, and keeps a running count of emitted bytes.
//
// Build option: define LZW_FEEDER_DBLBUF_EN to add a second word buffer. This
// makes word_ready a plain register output with no combinational path from
// stall. Without it, word_ready is only raised while idle or on the cycle the
// last byte of the active word is shifted out.
module lzw_byte_feeder #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [3:0]       word_nbytes,
  input  logic             word_last,
  input  logic             stall,
  output logic [7:0]       byte_out,
  output logic             shift,
  output logic             stream_done,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]       state;
  logic [63:0]      a_word;
  logic [3:0]       a_n;
  logic             a_last;
  logic [2:0]       idx;
  logic [CNT_W-1:0] byte_cnt;
  logic             done_q;
  logic [1:0]       done_pend;

  logic [3:0]       in_n;
  logic             xfer;
  logic             a_done;
  logic             a_free;
  logic             load_take;
  logic [63:0]      load_word;
  logic [3:0]       load_n;
  logic             load_last;
  logic             ev_a;
  logic             ev_z;
  logic [2:0]       done_total;

  // Byte counts above 8 cannot exist in a 64-bit word, so treat them as full.
  assign in_n = (word_nbytes > 4'd8) ? 4'd8 : word_nbytes;

  // A byte leaves whenever a word is active and downstream is not stalled.
  assign shift    = (state == ST_EMIT) & ~stall;
  assign byte_out = (state == ST_EMIT) ? a_word[{idx, 3'b000} +: 8] : 8'h00;

  // The active word finishes on the cycle its final byte is shifted out; that
  // same cycle is when a new word may take its place without a bubble.
  assign a_done = shift & ({1'b0, idx} == (a_n - 4'd1));
  assign a_free = (state == ST_IDLE) | a_done;

  assign xfer = word_valid & word_ready;

`ifdef LZW_FEEDER_DBLBUF_EN
  logic [63:0] b_word;
  logic [3:0]  b_n;
  logic        b_last;
  logic        b_full;

  // With a spare buffer, readiness depends only on that buffer being empty.
  assign word_ready = ~b_full;

  // A buffered word always has priority over a fresh one; while B is full no
  // fresh word can transfer anyway because word_ready is low.
  assign load_take = a_free & (b_full | xfer);
  assign load_word = b_full ? b_word : word_in;
  assign load_n    = b_full ? b_n    : in_n;
  assign load_last = b_full ? b_last : word_last;

  // Second buffer: catches a word that arrives while A is still emitting and
  // hands it over on A's completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_full <= 1'b0;
      b_word <= '0;
      b_n    <= '0;
      b_last <= 1'b0;
    end else if (b_full && a_free) begin
      b_full <= 1'b0;
    end else if (xfer && !a_free) begin
      b_full <= 1'b1;
      b_word <= word_in;
      b_n    <= in_n;
      b_last <= word_last;
    end
  end
`else
  // Single buffer: accept only when A is empty or finishing this cycle, which
  // makes readiness depend combinationally on stall.
  assign word_ready = a_free;
  assign load_take  = xfer;
  assign load_word  = word_in;
  assign load_n     = in_n;
  assign load_last  = word_last;
`endif

  // End-of-stream events: the active last word finishing, or a last-flagged
  // word with no bytes being retired straight away.
  assign ev_a = a_done & a_last;
  assign ev_z = load_take & (load_n == 4'd0) & load_last;

  // Active buffer and emission FSM. A zero-byte word never occupies A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_word <= '0;
      a_n    <= '0;
      a_last <= 1'b0;
      idx    <= '0;
    end else if (load_take && (load_n != 4'd0)) begin
      state  <= ST_EMIT;
      a_word <= load_word;
      a_n    <= load_n;
      a_last <= load_last;
      idx    <= '0;
    end else if (a_free) begin
      state <= ST_IDLE;
    end else if (shift) begin
      idx <= idx + 3'd1;
    end
  end

  // Running byte count, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (shift) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign bytes_sent = byte_cnt;

  // Two end-of-stream events can land in one cycle; the surplus is queued so
  // every last-flagged word still gets its own one-cycle pulse.
  assign done_total = {1'b0, done_pend} + {2'b00, ev_a} + {2'b00, ev_z};

  // Registered stream_done pulse plus small backlog of pending pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      done_pend <= '0;
    end else begin
      done_q <= (done_total != 3'd0);
      if (done_total == 3'd0) begin
        done_pend <= 2'd0;
      end else if (done_total > 3'd4) begin
        done_pend <= 2'd3;
      end else begin
        done_pend <= 2'(done_total - 3'd1);
      end
    end
  end

  assign stream_done = done_q;

endmodule
